// File: rtl/i2c_timeout_ctrl.sv
// I2C bus-stuck watchdog: arms a downstream timer while SCL or SDA is low and
// clocks SCL to free the bus on timeout. Optional fault counter: TIMEOUT_FAULT_CNT_EN.
module i2c_timeout_ctrl #(
    parameter logic [15:0] TICK_DIV     = 16'd50000,
    parameter logic [15:0] RECOVER_HALF = 16'd250,
    parameter logic [3:0]  RECOVER_CLKS = 4'd9
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       timeout,
    output logic       cnt_en,
    output logic       cnt_pulse,
    output logic       scl_oe,
    output logic       recover_busy,
    output logic       recover_done,
    output logic [7:0] fault_cnt
);

    typedef enum logic [1:0] {IDLE, WATCH, RECOVER, DONE} state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [1:0]  bus_raw;
    logic [1:0]  bus_sync;
    logic        scl_s;
    logic        sda_s;
    logic [15:0] presc_reg;
    logic [15:0] half_reg;
    logic [3:0]  pulse_reg;
    logic        scl_oe_reg;
    logic        half_end;
    logic        recover_enter;

    assign bus_raw = {sda_in, scl_in};

    // Bit 0 = SCL, bit 1 = SDA; both idle high so the synchronizers reset to 1.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= bus_raw[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign bus_sync[gi] = sync_reg;
        end
    endgenerate

    assign scl_s = bus_sync[0];
    assign sda_s = bus_sync[1];

    assign half_end      = (half_reg == RECOVER_HALF - 16'd1);
    assign recover_enter = (state_reg == WATCH) && (state_next == RECOVER);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!scl_s || !sda_s) begin
                    state_next = WATCH;
                end
            end
            WATCH: begin
                // Timeout takes priority over a simultaneous bus release.
                if (timeout) begin
                    state_next = RECOVER;
                end else if (scl_s && sda_s) begin
                    state_next = IDLE;
                end
            end
            RECOVER: begin
                if (half_end && !scl_oe_reg &&
                    (sda_s || (pulse_reg == RECOVER_CLKS - 4'd1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cnt_en       = (state_reg == WATCH);
    assign recover_busy = (state_reg == RECOVER);
    assign recover_done = (state_reg == DONE);
    assign cnt_pulse    = cnt_en && (presc_reg == TICK_DIV - 16'd1);
    assign scl_oe       = scl_oe_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_reg <= 16'd0;
        end else if (!cnt_en || cnt_pulse) begin
            presc_reg <= 16'd0;
        end else begin
            presc_reg <= presc_reg + 16'd1;
        end
    end

    // pulse_reg counts completed low/high pulses before the current one.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scl_oe_reg <= 1'b0;
            half_reg   <= 16'd0;
            pulse_reg  <= 4'd0;
        end else if (recover_enter) begin
            scl_oe_reg <= 1'b1;
            half_reg   <= 16'd0;
            pulse_reg  <= 4'd0;
        end else if (state_reg == RECOVER) begin
            if (half_end) begin
                half_reg <= 16'd0;
                if (scl_oe_reg) begin
                    scl_oe_reg <= 1'b0;
                end else if (state_next == RECOVER) begin
                    scl_oe_reg <= 1'b1;
                    pulse_reg  <= pulse_reg + 4'd1;
                end
            end else begin
                half_reg <= half_reg + 16'd1;
            end
        end else begin
            scl_oe_reg <= 1'b0;
            half_reg   <= 16'd0;
            pulse_reg  <= 4'd0;
        end
    end

`ifdef TIMEOUT_FAULT_CNT_EN
    logic [7:0] fault_reg;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fault_reg <= 8'h00;
        end else if (recover_enter && (fault_reg != 8'hFF)) begin
            fault_reg <= fault_reg + 8'h01;
        end
    end

    assign fault_cnt = fault_reg;
`else
    assign fault_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_i2c_timeout_ctrl.sv
// Self-checking bench for i2c_timeout_ctrl: per-cycle vector table plus
// multi-cycle timeout/recovery sequences against a behavioural 1000-tick timer.
module tb_i2c_timeout_ctrl;

    localparam int TIMER_TICKS = 1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_in;
    logic       sda_in;
    logic       timeout;
    logic       force_to;
    logic       cnt_en;
    logic       cnt_pulse;
    logic       scl_oe;
    logic       recover_busy;
    logic       recover_done;
    logic [7:0] fault_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_timeout_ctrl #(
        .TICK_DIV    (16'd4),
        .RECOVER_HALF(16'd2),
        .RECOVER_CLKS(4'd9)
    ) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .scl_in      (scl_in),
        .sda_in      (sda_in),
        .timeout     (timeout),
        .cnt_en      (cnt_en),
        .cnt_pulse   (cnt_pulse),
        .scl_oe      (scl_oe),
        .recover_busy(recover_busy),
        .recover_done(recover_done),
        .fault_cnt   (fault_cnt)
    );

    // Downstream timer model: clears while cnt_en is low, flags after TIMER_TICKS ticks.
    int tcnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= 0;
        end else if (!cnt_en) begin
            tcnt <= 0;
        end else if (cnt_pulse && tcnt < TIMER_TICKS) begin
            tcnt <= tcnt + 1;
        end
    end
    assign timeout = (tcnt == TIMER_TICKS) || force_to;

    typedef struct {
        logic [2:0] inp;    // {scl_in, sda_in, force_to}
        logic [4:0] exp;    // {cnt_en, cnt_pulse, scl_oe, recover_busy, recover_done}
        logic [7:0] fault;  // fault count expected when the counter is built in
    } vec_t;

    vec_t vecs[27];

    function automatic logic [7:0] fexp(input logic [7:0] n);
`ifdef TIMEOUT_FAULT_CNT_EN
        return n;
`else
        return 8'h00 & n;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        scl_in   = 1'b1;
        sda_in   = 1'b1;
        force_to = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int  en_cyc;
        int  pl_cyc;
        int  rises;
        int  done_cnt;
        int  bad;
        bit  found;
        bit  prev_oe;
        bit  busy_seen;
        bit  watch_seen;
        logic [3:0] oe_seq;

        // Short stretch then a bus release coinciding with timeout.
        vecs[0]  = '{3'b010, 5'b00000, 8'd0};
        vecs[1]  = '{3'b010, 5'b00000, 8'd0};
        vecs[2]  = '{3'b010, 5'b00000, 8'd0};
        vecs[3]  = '{3'b010, 5'b10000, 8'd0};
        vecs[4]  = '{3'b010, 5'b10000, 8'd0};
        vecs[5]  = '{3'b010, 5'b10000, 8'd0};
        vecs[6]  = '{3'b010, 5'b11000, 8'd0};
        vecs[7]  = '{3'b010, 5'b10000, 8'd0};
        vecs[8]  = '{3'b010, 5'b10000, 8'd0};
        vecs[9]  = '{3'b010, 5'b10000, 8'd0};
        vecs[10] = '{3'b010, 5'b11000, 8'd0};
        vecs[11] = '{3'b110, 5'b10000, 8'd0};
        vecs[12] = '{3'b110, 5'b10000, 8'd0};
        vecs[13] = '{3'b110, 5'b10000, 8'd0};
        vecs[14] = '{3'b110, 5'b00000, 8'd0};
        vecs[15] = '{3'b100, 5'b00000, 8'd0};
        vecs[16] = '{3'b100, 5'b00000, 8'd0};
        vecs[17] = '{3'b100, 5'b00000, 8'd0};
        vecs[18] = '{3'b110, 5'b10000, 8'd0};
        vecs[19] = '{3'b110, 5'b10000, 8'd0};
        vecs[20] = '{3'b111, 5'b10000, 8'd0};
        vecs[21] = '{3'b110, 5'b00110, 8'd1};
        vecs[22] = '{3'b110, 5'b00110, 8'd1};
        vecs[23] = '{3'b110, 5'b00010, 8'd1};
        vecs[24] = '{3'b110, 5'b00010, 8'd1};
        vecs[25] = '{3'b110, 5'b00001, 8'd1};
        vecs[26] = '{3'b110, 5'b00000, 8'd1};

        // Reset values, observed while reset is held.
        rst_n = 1'b0; scl_in = 1'b1; sda_in = 1'b1; force_to = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt_en", cnt_en, 0);
        check("rst_cnt_pulse", cnt_pulse, 0);
        check("rst_scl_oe", scl_oe, 0);
        check("rst_busy", recover_busy, 0);
        check("rst_done", recover_done, 0);
        check("rst_fault", fault_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cnt_en || cnt_pulse || scl_oe || recover_done) bad++;
        end
        check("idle_quiet_cycles", bad, 0);
        $display("idle: 100 cycles, active-output cycles=%0d", bad);

        for (int i = 0; i < 27; i++) begin
            @(posedge clk);
            #1;
            scl_in   = vecs[i].inp[2];
            sda_in   = vecs[i].inp[1];
            force_to = vecs[i].inp[0];
            @(negedge clk);
            $display("vec %0d: scl=%b sda=%b to=%b -> en=%b pulse=%b oe=%b busy=%b done=%b fault=%0d",
                     i, scl_in, sda_in, force_to, cnt_en, cnt_pulse, scl_oe,
                     recover_busy, recover_done, fault_cnt);
            check($sformatf("vec%0d_cnt_en", i), cnt_en, vecs[i].exp[4]);
            check($sformatf("vec%0d_cnt_pulse", i), cnt_pulse, vecs[i].exp[3]);
            check($sformatf("vec%0d_scl_oe", i), scl_oe, vecs[i].exp[2]);
            check($sformatf("vec%0d_busy", i), recover_busy, vecs[i].exp[1]);
            check($sformatf("vec%0d_done", i), recover_done, vecs[i].exp[0]);
            check($sformatf("vec%0d_fault", i), fault_cnt, fexp(vecs[i].fault));
        end
        force_to = 1'b0;

        // 50-cycle SCL stretch: no timeout, one tick every 4 cycles.
        do_reset();
        en_cyc = 0; pl_cyc = 0; busy_seen = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clk);
            #1 scl_in = (c < 50) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (cnt_en) en_cyc++;
            if (cnt_pulse) pl_cyc++;
            if (recover_busy || scl_oe) busy_seen = 1;
        end
        check("stretch_en_cycles", en_cyc, 50);
        check("stretch_pulses", pl_cyc, 12);
        check("stretch_no_recovery", busy_seen, 0);
        $display("stretch: en_cycles=%0d pulses=%0d recovery=%b", en_cyc, pl_cyc, busy_seen);

        // Stuck SCL: 1000 ticks of 4 cycles, then one pulse (SDA is high).
        do_reset();
        scl_in = 1'b0;
        en_cyc = 0; found = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (timeout) begin
                found = 1;
                break;
            end
            if (cnt_en) en_cyc++;
        end
        check("stuck_scl_timeout_seen", found, 1);
        check("stuck_scl_cycles", en_cyc, 4000);
        oe_seq = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            oe_seq = {oe_seq[2:0], scl_oe};
            if (j == 0) begin
                check("stuck_scl_busy", recover_busy, 1);
                check("stuck_scl_en_off", cnt_en, 0);
            end
        end
        check("stuck_scl_oe_seq", oe_seq, 4'b1100);
        @(negedge clk);
        check("stuck_scl_done", recover_done, 1);
        check("stuck_scl_oe_at_done", scl_oe, 0);
        check("stuck_scl_fault", fault_cnt, fexp(8'd1));
        $display("stuck scl: cycles=%0d oe_seq=%b fault=%0d", en_cyc, oe_seq, fault_cnt);
        scl_in = 1'b1;

        // Stuck SDA released during the 3rd pulse.
        do_reset();
        sda_in = 1'b0;
        rises = 0; done_cnt = 0; prev_oe = 0; bad = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (scl_oe && !prev_oe) begin
                rises++;
                if (rises == 3) sda_in = 1'b1;
            end
            prev_oe = scl_oe;
            if (recover_done) begin
                done_cnt++;
                if (scl_oe) bad++;
                break;
            end
        end
        check("sda_early_done_seen", done_cnt, 1);
        check("sda_early_pulses", rises, 3);
        check("sda_early_oe_at_done", bad, 0);
        check("sda_early_fault", fault_cnt, fexp(8'd1));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (recover_done || scl_oe || cnt_en) done_cnt++;
        end
        check("sda_early_quiet_after", done_cnt, 1);
        $display("sda early release: pulses=%0d fault=%0d", rises, fault_cnt);

        // Stuck SDA never released: 9 pulses, re-watch, second timeout.
        do_reset();
        sda_in = 1'b0;
        rises = 0; done_cnt = 0; prev_oe = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (scl_oe && !prev_oe) rises++;
            prev_oe = scl_oe;
            if (recover_done) begin
                done_cnt++;
                break;
            end
        end
        check("exhaust_done_seen", done_cnt, 1);
        check("exhaust_pulses", rises, 9);
        found = 0; watch_seen = 0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (cnt_en) watch_seen = 1;
            if (recover_busy) begin
                found = 1;
                break;
            end
        end
        check("exhaust_rewatch", watch_seen, 1);
        check("exhaust_second_recovery", found, 1);
        check("exhaust_fault", fault_cnt, fexp(8'd2));
        $display("exhausted: pulses=%0d fault=%0d", rises, fault_cnt);

        // Reset during the 4th pulse of the second recovery.
        rises = 0; prev_oe = 0; found = 0;
        for (int n = 0; n < 200; n++) begin
            if (n > 0) @(negedge clk);
            if (scl_oe && !prev_oe) rises++;
            prev_oe = scl_oe;
            if (rises == 4) begin
                found = 1;
                break;
            end
        end
        check("midrst_reached_pulse4", found, 1);
        check("midrst_oe_before", scl_oe, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_oe_async", scl_oe, 0);
        check("midrst_busy_async", recover_busy, 0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (scl_oe) bad++;
        end
        check("midrst_oe_held", bad, 0);
        check("midrst_fault", fault_cnt, 0);
        $display("mid-recovery reset: pulse=%0d oe_after=%b", rises, scl_oe);
        @(posedge clk);
        #1 rst_n = 1'b1;
        sda_in = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_timeout_ctrl.md
I2C_TIMEOUT_CTRL -- requirements
Module: i2c_timeout_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 16'd50000: sys_clk cycles per cnt_pulse tick (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter RECOVER_HALF, default 16'd250: sys_clk cycles per SCL half-period during recovery; legal range 1..65535.
REQ-003 Parameter RECOVER_CLKS, default 4'd9: maximum SCL pulses per recovery; legal range 1..15.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 scl_in  in  1  raw I2C SCL level, asynchronous to sys_clk.
REQ-007 sda_in  in  1  raw I2C SDA level, asynchronous to sys_clk.
REQ-008 timeout  in  1  expiry flag from the downstream 1 s timer.
REQ-009 cnt_en  out  1  timer enable; timer clears while low.
REQ-010 cnt_pulse  out  1  one-cycle tick to the timer.
REQ-011 scl_oe  out  1  1 = pull SCL low (open-drain enable).
REQ-012 recover_busy  out  1  high while recovery is in progress.
REQ-013 recover_done  out  1  one-cycle pulse when recovery completes.
REQ-014 fault_cnt  out  8  count of timeouts that started a recovery.

Function
REQ-015 scl_in and sda_in SHALL each pass through a 2-flop synchronizer that resets to 1; the FSM uses only the synchronized values scl_s and sda_s.
REQ-016 The FSM SHALL have four states: IDLE, WATCH, RECOVER and DONE.
REQ-017 IDLE: go to WATCH when scl_s==0 or sda_s==0.
REQ-018 WATCH: go to IDLE when scl_s==1 and sda_s==1; go to RECOVER when timeout==1; if both occur in the same cycle, timeout SHALL win.
REQ-019 cnt_en SHALL equal (state==WATCH) as a registered-state decode; scl_in falling from idle-high SHALL raise cnt_en on the 3rd rising edge.
REQ-020 Prescaler: 16-bit counter, held at 0 while cnt_en==0, otherwise counts 0..TICK_DIV-1 and wraps.
REQ-021 cnt_pulse SHALL be high for exactly one cycle when cnt_en==1 and the prescaler equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after arming.
REQ-022 RECOVER: cnt_en=0; scl_oe SHALL assert on entry and toggle every RECOVER_HALF cycles, driven by a 16-bit half-period counter.
REQ-023 One pulse SHALL be counted each time scl_oe rises (low phase begins) after the first.
REQ-024 At the end of each released (high) phase, go to DONE if sda_s==1 or RECOVER_CLKS pulses have completed, with scl_oe left at 0.
REQ-025 DONE SHALL last one cycle with recover_done=1, then return to IDLE.
REQ-026 recover_busy SHALL equal (state==RECOVER).
REQ-027 scl_oe SHALL be 0 in every state other than RECOVER.

Reset
REQ-028 While sys_rst_n==0, all of the following SHALL hold: state=IDLE; synchronizers=1; cnt_en=0; cnt_pulse=0; scl_oe=0; recover_busy=0; recover_done=0; prescaler, half-period and pulse counters=0; fault_cnt=0.
REQ-029 Reset asserted mid-recovery SHALL release scl_oe immediately (asynchronously), with no further toggling.

Configuration
REQ-030 Macro TIMEOUT_FAULT_CNT_EN defined: fault_cnt increments by 1 on each WATCH->RECOVER transition and saturates at 8'hFF.
REQ-031 Macro TIMEOUT_FAULT_CNT_EN undefined: fault_cnt is tied to 8'h00, no counter flops exist, and the port list is unchanged.

Verification (TICK_DIV=4, RECOVER_HALF=2, RECOVER_CLKS=9, real timer_1s downstream, macro defined)
REQ-032 Reset check: reset, then hold scl_in=sda_in=1 for 100 cycles -> cnt_en, cnt_pulse, scl_oe and recover_done stay 0.
REQ-033 Short stretch: scl_in=0 for 50 cycles, then 1 -> cnt_en is high for 50 cycles; cnt_pulse pulses every 4th cycle; no timeout, no recovery.
REQ-034 Stuck SCL: scl_in held 0 -> timeout after 1000 ticks (about 4000 cycles); then recover_busy=1 and cnt_en=0 in the following cycle; scl_oe toggles every 2 cycles.
REQ-035 Stuck SDA released early: sda_in held 0 until timeout, then released after the 3rd pulse -> DONE at the end of that high phase, recover_done pulses once, scl_oe=0, fault_cnt=1.
REQ-036 Stuck SDA, recovery exhausted: sda_in never released -> exactly 9 scl_oe pulses, then recover_done; a new watch starts and fault_cnt reaches 2 after the next timeout.
REQ-037 Edge cases: assert reset during the 4th recovery pulse -> scl_oe drops in the same cycle; release the bus in the same cycle as timeout -> the FSM enters RECOVER.
